// File: rtl/gcm_pkg.sv
// gcm_pkg: shared types, constants and helpers for the GCM receive/verify path.
//   block_t      128-bit GCM block, MSB-first (vector bit 127 = GCM bit 0)
//   GCM_R        GF(2^128) reduction constant 0xE1 || 0^120
//   state_t      verify FSM states
//   len_block    packs len(A) || len(C) into the final GHASH block
//   blk_count    bit length -> number of 128-bit blocks (ceil)
//   last_mask    keep-mask for a trailing partial block
package gcm_pkg;

  typedef logic [127:0] block_t;

  localparam block_t GCM_R = {8'hE1, 120'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AAD,
    ST_CT,
    ST_LEN,
    ST_MUL,
    ST_DONE
  } state_t;

  function automatic block_t len_block(input logic [63:0] aad_bits,
                                       input logic [63:0] ct_bits);
    return {aad_bits, ct_bits};
  endfunction

  // Sizes beyond 2^32 blocks are out of range, so the count is truncated.
  function automatic logic [31:0] blk_count(input logic [63:0] size_bits);
    return 32'((size_bits >> 7) + 64'(|size_bits[6:0]));
  endfunction

  // rem = valid bits in the last block; 0 means the block is full.
  function automatic block_t last_mask(input logic [6:0] rem);
    block_t ones;
    ones = '1;
    return (rem == 7'd0) ? ones : ~(ones >> rem);
  endfunction

endpackage

// File: rtl/gf128_mul_digit.sv
// gf128_mul_digit: digit-serial GF(2^128) multiplier, GCM bit order.
// Processes DIGIT bits of X per cycle, N = 128/DIGIT cycles per product.
// Ports:
//   clk, rst    clock, async active-high reset
//   i_clear     zero the accumulator (start of a new message)
//   i_start     load X and H, begin a product (accumulator restarts at 0)
//   i_x, i_h    operands, MSB = GCM bit 0
//   o_z         accumulator; holds X*H once o_busy is low
//   o_busy      product in progress
//   o_done      high in the cycle whose rising edge completes the product
module gf128_mul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_clear,
  input  logic   i_start,
  input  block_t i_x,
  input  block_t i_h,
  output block_t o_z,
  output logic   o_busy,
  output logic   o_done
);

  localparam int N  = 128 / DIGIT;
  localparam int CW = $clog2(N + 1);

  block_t        r_x;
  block_t        r_z;
  block_t        r_v;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  block_t w_z_nxt;
  block_t w_v_nxt;

  // Top DIGIT bits of r_x are the next GCM bits to consume; V is H shifted
  // right (GCM order) once per consumed bit, folding in R on carry-out.
  always_comb begin
    w_z_nxt = r_z;
    w_v_nxt = r_v;
    for (int d = 0; d < DIGIT; d++) begin
      if (r_x[127-d]) w_z_nxt = w_z_nxt ^ w_v_nxt;
      w_v_nxt = (w_v_nxt >> 1) ^ (w_v_nxt[0] ? GCM_R : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_z    <= '0;
      r_v    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_clear) begin
      r_z    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_x    <= i_x;
      r_v    <= i_h;
      r_z    <= '0;
      r_cnt  <= CW'(N);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_x   <= r_x << DIGIT;
      r_z   <= w_z_nxt;
      r_v   <= w_v_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_z    = r_z;
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(1));

endmodule

// File: rtl/gcm_tag_verify.sv
// gcm_tag_verify: GCM receive back end. Decrypts ciphertext with supplied
// keystream blocks, runs GHASH over AAD || C || len, and checks the tag.
// All 128/64-bit vectors are MSB-first: vector MSB = GCM bit 0.
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_start                       message start (IDLE only)
//   i_h, i_encrypted_j0, i_tag    H, E(K,J0), received tag (captured at start)
//   i_aad_size, i_cipher_text_size  lengths in bits (captured at start)
//   i_blk_valid / o_blk_ready     block handshake; i_blk, i_keystream data
//   o_plain_text, o_pt_valid      recovered plaintext, one-cycle strobe
//   o_busy, o_done, o_auth_ok     status; o_auth_ok valid from o_done
//
// state   | meaning
// IDLE    | waiting for i_start
// AAD     | accepting AAD blocks, one per multiply
// CT      | accepting ciphertext blocks, emitting plaintext
// LEN     | launch the length-block multiply
// MUL     | waiting for the length-block multiply
// DONE    | compare S with tag, strobe o_done
module gcm_tag_verify
  import gcm_pkg::*;
#(
  parameter int DIGIT    = 8,
  parameter int TAG_BITS = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [127:0]  i_h,
  input  logic [127:0]  i_encrypted_j0,
  input  logic [127:0]  i_tag,
  input  logic [63:0]   i_aad_size,
  input  logic [63:0]   i_cipher_text_size,
  input  logic          i_blk_valid,
  output logic          o_blk_ready,
  input  logic [127:0]  i_blk,
  input  logic [127:0]  i_keystream,
  output logic [127:0]  o_plain_text,
  output logic          o_pt_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_auth_ok
);

  state_t      r_state;
  state_t      w_state_nxt;
  block_t      r_h;
  block_t      r_ej0;
  block_t      r_tag;
  logic [63:0] r_aad_sz;
  logic [63:0] r_ct_sz;
  logic [31:0] r_blk_left;
  block_t      r_pt;
  logic        r_pt_valid;
  logic        r_done;
  logic        r_auth_ok;

  block_t      w_y;
  block_t      w_mul_x;
  logic        w_mul_start;
  logic        w_mul_clear;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic        w_accept;
  logic        w_start;
  logic [31:0] w_in_a;
  logic [31:0] w_in_c;
  logic [31:0] w_reg_c;
  logic [6:0]  w_rem;
  block_t      w_blk_mask;
  block_t      w_s;
  logic        w_tag_match;

  assign w_start  = (r_state == ST_IDLE) && i_start;
  assign w_in_a   = blk_count(i_aad_size);
  assign w_in_c   = blk_count(i_cipher_text_size);
  assign w_reg_c  = blk_count(r_ct_sz);

  // r_blk_left counts down blocks of the current phase; at 1 the offered
  // block is the last one and may be partial.
  assign w_rem      = (r_state == ST_AAD) ? r_aad_sz[6:0] : r_ct_sz[6:0];
  assign w_blk_mask = (r_blk_left == 32'd1) ? last_mask(w_rem) : '1;

  assign o_blk_ready = ((r_state == ST_AAD) || (r_state == ST_CT)) &&
                       !w_mul_busy && (r_blk_left != 32'd0);
  assign w_accept    = i_blk_valid && o_blk_ready;

  // Y is the multiplier accumulator itself; it is cleared at message start.
  assign w_mul_clear = w_start;
  assign w_mul_start = w_accept || (r_state == ST_LEN);
  assign w_mul_x     = w_y ^ ((r_state == ST_LEN) ? len_block(r_aad_sz, r_ct_sz)
                                                  : (i_blk & w_blk_mask));

  assign w_s         = w_y ^ r_ej0;
  assign w_tag_match = (((w_s ^ r_tag) >> (128 - TAG_BITS)) == '0);

  gf128_mul_digit #(.DIGIT(DIGIT)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_mul_clear),
    .i_start (w_mul_start),
    .i_x     (w_mul_x),
    .i_h     (r_h),
    .o_z     (w_y),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done)
  );

  // Phase changes happen on the edge that completes the last multiply, so
  // the next phase's first block (or the length multiply) follows at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (w_in_a != 32'd0) ? ST_AAD :
                                          (w_in_c != 32'd0) ? ST_CT : ST_LEN;
      ST_AAD:  if (w_mul_done && (r_blk_left == 32'd0))
                 w_state_nxt = (w_reg_c != 32'd0) ? ST_CT : ST_LEN;
      ST_CT:   if (w_mul_done && (r_blk_left == 32'd0)) w_state_nxt = ST_LEN;
      ST_LEN:  w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_h        <= '0;
      r_ej0      <= '0;
      r_tag      <= '0;
      r_aad_sz   <= '0;
      r_ct_sz    <= '0;
      r_blk_left <= '0;
      r_pt       <= '0;
      r_pt_valid <= 1'b0;
      r_done     <= 1'b0;
      r_auth_ok  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pt_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_start) begin
        r_h        <= i_h;
        r_ej0      <= i_encrypted_j0;
        r_tag      <= i_tag;
        r_aad_sz   <= i_aad_size;
        r_ct_sz    <= i_cipher_text_size;
        r_blk_left <= (w_in_a != 32'd0) ? w_in_a : w_in_c;
        r_auth_ok  <= 1'b0;
      end
      if (w_accept) begin
        r_blk_left <= r_blk_left - 32'd1;
        if (r_state == ST_CT) begin
          r_pt       <= (i_blk ^ i_keystream) & w_blk_mask;
          r_pt_valid <= 1'b1;
        end
      end
      if ((r_state == ST_AAD) && (w_state_nxt == ST_CT)) r_blk_left <= w_reg_c;
      if (r_state == ST_DONE) begin
        r_done    <= 1'b1;
        r_auth_ok <= w_tag_match;
      end
    end
  end

  assign o_plain_text = r_pt;
  assign o_pt_valid   = r_pt_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_auth_ok    = r_auth_ok;

endmodule

// File: tb/tb_gcm_tag_verify.sv
module tb_gcm_tag_verify;

  localparam int DIGIT = 8;
  localparam int N     = 128 / DIGIT;

  localparam logic [127:0] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] NIST_EJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] NIST_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] NIST_T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [127:0] i_h, i_encrypted_j0, i_tag;
  logic [63:0]  i_aad_size, i_cipher_text_size;
  logic         i_blk_valid;
  logic         o_blk_ready;
  logic [127:0] i_blk, i_keystream;
  logic [127:0] o_plain_text;
  logic         o_pt_valid, o_busy, o_done, o_auth_ok;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pt_cnt = 0;
  int done_cnt = 0;

  logic [127:0] m_blk[$];
  logic [127:0] m_ks[$];

  gcm_tag_verify #(.DIGIT(DIGIT), .TAG_BITS(128)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_h                (i_h),
    .i_encrypted_j0     (i_encrypted_j0),
    .i_tag              (i_tag),
    .i_aad_size         (i_aad_size),
    .i_cipher_text_size (i_cipher_text_size),
    .i_blk_valid        (i_blk_valid),
    .o_blk_ready        (o_blk_ready),
    .i_blk              (i_blk),
    .i_keystream        (i_keystream),
    .o_plain_text       (o_plain_text),
    .o_pt_valid         (o_pt_valid),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_auth_ok          (o_auth_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_pt_valid) pt_cnt <= pt_cnt + 1;
    if (o_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  // Reference: textbook bit-at-a-time GF(2^128) product in GCM bit order.
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    logic lsb;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      lsb = v[0];
      v = v >> 1;
      if (lsb) v ^= {8'hE1, 120'd0};
    end
    return z;
  endfunction

  function automatic int nblk(input logic [63:0] sz);
    return int'((sz + 64'd127) / 64'd128);
  endfunction

  function automatic int vbits(input logic [63:0] sz, input int j);
    longint r = longint'(sz) - 128 * longint'(j);
    return (r >= 128) ? 128 : int'(r);
  endfunction

  function automatic logic [127:0] trunc_blk(input logic [127:0] b, input int keep);
    for (int i = keep; i < 128; i++) b[127-i] = 1'b0;
    return b;
  endfunction

  function automatic logic [127:0] ghash_model(input logic [127:0] h,
                                               input logic [63:0] asz, input logic [63:0] csz);
    logic [127:0] y = '0;
    int na = nblk(asz);
    int nc = nblk(csz);
    for (int j = 0; j < na; j++) y = gmul(y ^ trunc_blk(m_blk[j], vbits(asz, j)), h);
    for (int j = 0; j < nc; j++) y = gmul(y ^ trunc_blk(m_blk[na+j], vbits(csz, j)), h);
    return gmul(y ^ {asz, csz}, h);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Blocks come from m_blk/m_ks (AAD first). exp_auth < 0: use the model.
  // abort_at >= 0: reset right after accepting that block index.
  task automatic send_msg(input string nm, input logic [127:0] h, input logic [127:0] ej0,
                          input logic [127:0] tag, input logic [63:0] asz,
                          input logic [63:0] csz, input int exp_auth, input bit poke,
                          input int abort_at);
    int na, nc, nt, s_edge, k_edge, low, guard, pt0, dn0;
    logic [127:0] exp_s;
    logic exp_ok;
    na = nblk(asz);
    nc = nblk(csz);
    nt = na + nc;
    exp_s  = ghash_model(h, asz, csz) ^ ej0;
    exp_ok = (exp_auth < 0) ? (exp_s == tag) : exp_auth[0];
    pt0 = pt_cnt;
    dn0 = done_cnt;
    i_h = h; i_encrypted_j0 = ej0; i_tag = tag;
    i_aad_size = asz; i_cipher_text_size = csz;
    i_start = 1'b1;
    @(posedge clk); #1;
    s_edge = cyc;
    k_edge = s_edge;
    i_start = 1'b0;
    i_h = ~h; i_encrypted_j0 = rnd128(); i_tag = ~tag;
    i_aad_size = 64'(~asz); i_cipher_text_size = 64'(~csz);
    chk({nm, " busy after start"}, o_busy, 1);
    for (int b = 0; b < nt; b++) begin
      i_blk = m_blk[b];
      i_keystream = m_ks[b];
      i_blk_valid = 1'b1;
      guard = 0;
      while (!o_blk_ready && guard < 4 * N) begin
        @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      k_edge = cyc;
      chk({nm, " pt_valid on accept"}, o_pt_valid, (b >= na));
      if (b >= na)
        chk({nm, " plaintext"}, o_plain_text,
            trunc_blk(m_blk[b] ^ m_ks[b], vbits(csz, b - na)));
      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        chk({nm, " rst ready"}, o_blk_ready, 0);
        chk({nm, " rst busy"}, o_busy, 0);
        chk({nm, " rst pt_valid"}, o_pt_valid, 0);
        chk({nm, " rst plaintext"}, o_plain_text, 0);
        chk({nm, " rst done/auth"}, {o_done, o_auth_ok}, 0);
        i_blk_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3 * N) @(posedge clk);
        #1;
        chk({nm, " no done after abort"}, done_cnt - dn0, 0);
        return;
      end
      if (b < nt - 1) begin
        i_blk = m_blk[b+1];
        i_keystream = m_ks[b+1];
        low = 0;
        while (!o_blk_ready && low <= 4 * N) begin
          i_start = (poke && b == 1 && low == 3);
          low++;
          @(posedge clk); #1;
        end
        i_start = 1'b0;
        chk({nm, " ready low cycles"}, low, N);
      end else begin
        i_blk_valid = 1'b0;
      end
    end
    guard = 0;
    while (!o_done && guard < 8 * N) begin
      @(posedge clk); #1; guard++;
    end
    chk({nm, " done edge"}, cyc, (nt == 0) ? s_edge + N + 2 : k_edge + 2 * N + 2);
    chk({nm, " auth_ok"}, o_auth_ok, exp_ok);
    chk({nm, " busy at done"}, o_busy, 0);
    @(posedge clk); #1;
    chk({nm, " done one cycle"}, o_done, 0);
    chk({nm, " auth_ok held"}, o_auth_ok, exp_ok);
    chk({nm, " pt count"}, pt_cnt - pt0, nc);
    chk({nm, " done count"}, done_cnt - dn0, 1);
  endtask

  initial begin
    logic [127:0] t, ks, h, ej0;
    logic [63:0] asz, csz;
    int na, nc;
    rst = 1'b1;
    i_start = 1'b0; i_h = '0; i_encrypted_j0 = '0; i_tag = '0;
    i_aad_size = '0; i_cipher_text_size = '0;
    i_blk_valid = 1'b0; i_blk = '0; i_keystream = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", o_blk_ready, 0);
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset auth_ok", o_auth_ok, 0);
    chk("reset pt_valid", o_pt_valid, 0);
    chk("reset plaintext", o_plain_text, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // NIST test case 1: empty message
    m_blk.delete(); m_ks.delete();
    send_msg("nist1", NIST_H, NIST_EJ0, NIST_EJ0, 64'd0, 64'd0, 1, 1'b0, -1);

    // NIST test case 2: one ciphertext block, keystream equals ciphertext
    m_blk = '{NIST_C}; m_ks = '{NIST_C};
    send_msg("nist2", NIST_H, NIST_EJ0, NIST_T2, 64'd0, 64'd128, 1, 1'b0, -1);
    chk("nist2 plaintext zero", o_plain_text, 0);

    // Case 2 with GCM bit 0 of C flipped
    t = NIST_C ^ {1'b1, 127'd0};
    m_blk = '{t}; m_ks = '{NIST_C};
    send_msg("nist2 flip", NIST_H, NIST_EJ0, NIST_T2, 64'd0, 64'd128, 0, 1'b0, -1);
    chk("nist2 flip plaintext", o_plain_text, {1'b1, 127'd0});

    // 100-bit ciphertext: plaintext ones in bits 0..99, zero tail
    ks = rnd128(); h = rnd128(); ej0 = rnd128();
    m_blk = '{ks ^ {128{1'b1}}}; m_ks = '{ks};
    send_msg("ct100", h, ej0, ghash_model(h, 64'd0, 64'd100) ^ ej0,
             64'd0, 64'd100, -1, 1'b0, -1);
    chk("ct100 plaintext", o_plain_text, 128'hFFFFFFFFFFFFFFFFFFFFFFFFF0000000);

    // 3 AAD + 2 CT blocks, valid held high, stray i_start mid-message
    m_blk.delete(); m_ks.delete();
    for (int i = 0; i < 5; i++) begin m_blk.push_back(rnd128()); m_ks.push_back(rnd128()); end
    h = rnd128(); ej0 = rnd128();
    send_msg("3aad2ct", h, ej0, ghash_model(h, 64'd384, 64'd256) ^ ej0,
             64'd384, 64'd256, -1, 1'b1, -1);

    // Reset during the first ciphertext block, then a clean case 2
    m_blk.delete(); m_ks.delete();
    for (int i = 0; i < 3; i++) begin m_blk.push_back(rnd128()); m_ks.push_back(rnd128()); end
    send_msg("abort", rnd128(), rnd128(), rnd128(), 64'd128, 64'd256, -1, 1'b0, 1);
    m_blk = '{NIST_C}; m_ks = '{NIST_C};
    send_msg("nist2 after rst", NIST_H, NIST_EJ0, NIST_T2, 64'd0, 64'd128, 1, 1'b0, -1);

    // Randomized messages, half with a corrupted tag
    for (int r = 0; r < 8; r++) begin
      asz = 64'($urandom_range(0, 400));
      csz = 64'($urandom_range(0, 500));
      na = nblk(asz); nc = nblk(csz);
      m_blk.delete(); m_ks.delete();
      for (int i = 0; i < na + nc; i++) begin m_blk.push_back(rnd128()); m_ks.push_back(rnd128()); end
      h = rnd128(); ej0 = rnd128();
      t = ghash_model(h, asz, csz) ^ ej0;
      if (r[0]) t[$urandom_range(0, 127)] ^= 1'b1;
      send_msg($sformatf("rand%0d", r), h, ej0, t, asz, csz, -1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
